// File: rtl/dlsc_cpu1_icache_fill.sv
// ---------------------------------------------------------------------------
// dlsc_cpu1_icache_fill
//
// Line-fill controller for the write side of the instruction-cache way array.
// A qualified miss from the fetch stage (word address + one-hot victim way)
// becomes a single line-aligned read burst to memory. The returned words are
// streamed into the victim way. The first beat writes the tag as valid but
// incomplete. The last beat marks the tag complete. The block also runs the
// invalidate sweep after reset or flush, touching every set once with wr_init.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   miss_i             fetch-stage miss, only looked at while idle
//   miss_addr_i        word address that missed
//   miss_waylru_i      one-hot victim way
//   flush_i            invalidate the whole cache (pulse)
//   busy_o             sweep or fill in progress; fetch must stall
//   fill_done_o        one-cycle pulse after the last line word was written
//   error_o            sticky; mem_rd_last disagreed with the beat count
//   mem_cmd_*          burst command (valid/ready, line address, beats-1)
//   mem_rd_*           burst read data (valid/ready, data, last)
//   wr_init_o          invalidate-sweep strobe
//   wr_addr_o          cache write address
//   wr_way_o           write way select
//   wr_en_o            data write strobe
//   wr_data_o          data write value
//   wr_en_tag_o        tag write strobe (valid bit follows wr_en)
//   wr_last_o          tag-complete marker on the final word
// ---------------------------------------------------------------------------
module dlsc_cpu1_icache_fill #(
    parameter int ADDR = 30,
    parameter int DATA = 32,
    parameter int LINE = 4,
    parameter int SIZE = 9,
    parameter int WAYS = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            miss_i,
    input  logic [ADDR-1:0] miss_addr_i,
    input  logic [WAYS-1:0] miss_waylru_i,
    input  logic            flush_i,

    output logic            busy_o,
    output logic            fill_done_o,
    output logic            error_o,

    input  logic            mem_cmd_ready_i,
    output logic            mem_cmd_valid_o,
    output logic [ADDR-1:0] mem_cmd_addr_o,
    output logic [LINE-1:0] mem_cmd_len_o,

    output logic            mem_rd_ready_o,
    input  logic            mem_rd_valid_i,
    input  logic [DATA-1:0] mem_rd_data_i,
    input  logic            mem_rd_last_i,

    output logic            wr_init_o,
    output logic [ADDR-1:0] wr_addr_o,
    output logic [WAYS-1:0] wr_way_o,
    output logic            wr_en_o,
    output logic [DATA-1:0] wr_data_o,
    output logic            wr_en_tag_o,
    output logic            wr_last_o
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    // Word-offset bits inside a line; cleared to form the burst address.
    localparam logic [ADDR-1:0] OFS_MASK = {{(ADDR-LINE){1'b0}}, {LINE{1'b1}}};

    state_t          state_q,      state_d;
    logic [SIZE-1:0] sweep_q,      sweep_d;
    logic [LINE-1:0] beat_q,       beat_d;
    logic [ADDR-1:0] line_q,       line_d;
    logic [WAYS-1:0] way_q,        way_d;
    logic            flush_pend_q, flush_pend_d;
    logic            error_q,      error_d;
    logic            busy_q,       busy_d;
    logic            fill_done_q,  fill_done_d;
    logic            wr_init_q,    wr_init_d;
    logic [ADDR-1:0] wr_addr_q,    wr_addr_d;
    logic [WAYS-1:0] wr_way_q,     wr_way_d;
    logic            wr_en_q,      wr_en_d;
    logic            wr_en_tag_q,  wr_en_tag_d;
    logic            wr_last_q,    wr_last_d;
    logic [DATA-1:0] wr_data_q,    wr_data_d;

    logic [SIZE-1:0] sweep_inc;
    logic            beat_final;

    assign sweep_inc  = sweep_q + 1'b1;
    assign beat_final = &beat_q;

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        beat_d       = beat_q;
        line_d       = line_q;
        way_d        = way_q;
        flush_pend_d = flush_pend_q;
        error_d      = error_q;
        busy_d       = busy_q;
        // The pulse lands one cycle after the cycle that carried the final write.
        fill_done_d  = wr_last_q;
        wr_init_d    = wr_init_q;
        wr_addr_d    = wr_addr_q;
        wr_way_d     = wr_way_q;
        wr_en_d      = 1'b0;
        wr_en_tag_d  = 1'b0;
        wr_last_d    = 1'b0;
        wr_data_d    = wr_data_q;

        unique case (state_q)
            ST_INIT: begin
                // Registered outputs always show the current sweep index.
                // Arriving from a fill, the output register still holds the
                // final line write, so the first INIT cycle only loads index 0.
                // A flush here restarts the sweep the same way.
                if (flush_i || !wr_init_q) begin
                    sweep_d   = '0;
                    wr_init_d = 1'b1;
                    wr_addr_d = '0;
                end else if (&sweep_q) begin
                    state_d   = ST_IDLE;
                    wr_init_d = 1'b0;
                    busy_d    = 1'b0;
                end else begin
                    sweep_d   = sweep_inc;
                    wr_addr_d = ADDR'(sweep_inc);
                end
            end

            ST_IDLE: begin
                // Flush beats a simultaneous miss; fetch will miss again later.
                if (flush_i) begin
                    state_d   = ST_INIT;
                    sweep_d   = '0;
                    wr_init_d = 1'b1;
                    wr_addr_d = '0;
                    busy_d    = 1'b1;
                end else if (miss_i) begin
                    state_d = ST_CMD;
                    line_d  = miss_addr_i & ~OFS_MASK;
                    way_d   = (WAYS == 1) ? {WAYS{1'b1}} : miss_waylru_i;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_CMD: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_cmd_ready_i) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // An accepted burst is always drained; a flush only picks the
                // state that follows it.
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rd_valid_i) begin
                    wr_en_d     = 1'b1;
                    wr_way_d    = way_q;
                    wr_addr_d   = line_q | ADDR'(beat_q);
                    wr_data_d   = mem_rd_data_i;
                    wr_en_tag_d = (beat_q == '0) || beat_final;
                    wr_last_d   = beat_final;
                    if (mem_rd_last_i != beat_final) begin
                        error_d = 1'b1;
                    end
                    // The burst length comes from the counter, not mem_rd_last.
                    beat_d = beat_q + 1'b1;
                    if (beat_final) begin
                        if (flush_pend_q || flush_i) begin
                            state_d      = ST_INIT;
                            sweep_d      = '0;
                            flush_pend_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            way_q        <= '0;
            flush_pend_q <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            fill_done_q  <= 1'b0;
            wr_init_q    <= 1'b1;
            wr_addr_q    <= '0;
            wr_way_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_en_tag_q  <= 1'b0;
            wr_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            way_q        <= way_d;
            flush_pend_q <= flush_pend_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            fill_done_q  <= fill_done_d;
            wr_init_q    <= wr_init_d;
            wr_addr_q    <= wr_addr_d;
            wr_way_q     <= wr_way_d;
            wr_en_q      <= wr_en_d;
            wr_en_tag_q  <= wr_en_tag_d;
            wr_last_q    <= wr_last_d;
        end
    end

    // Write data is qualified by wr_en, so it needs no reset.
    always_ff @(posedge clk) begin
        wr_data_q <= wr_data_d;
    end

    assign busy_o          = busy_q;
    assign fill_done_o     = fill_done_q;
    assign error_o         = error_q;

    assign mem_cmd_valid_o = (state_q == ST_CMD);
    assign mem_cmd_addr_o  = line_q;
    assign mem_cmd_len_o   = {LINE{1'b1}};
    assign mem_rd_ready_o  = (state_q == ST_DATA);

    assign wr_init_o       = wr_init_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_way_o        = wr_way_q;
    assign wr_en_o         = wr_en_q;
    assign wr_data_o       = wr_data_q;
    assign wr_en_tag_o     = wr_en_tag_q;
    assign wr_last_o       = wr_last_q;

endmodule

// File: tb/tb_dlsc_cpu1_icache_fill.sv
// Testbench for dlsc_cpu1_icache_fill (two-way configuration).
// A memory responder answers bursts with random data and random gaps and
// queues the cache writes those words must produce. A monitor pops and
// compares on every write strobe. The stimulus process issues misses,
// flushes and resets, and checks the invalidate sweeps.
module tb_dlsc_cpu1_icache_fill;

    localparam int ADDR  = 30;
    localparam int DATA  = 32;
    localparam int LINE  = 4;
    localparam int SIZE  = 9;
    localparam int WAYS  = 2;
    localparam int BEATS = 1 << LINE;
    localparam int SWEEP = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            miss;
    logic [ADDR-1:0] miss_addr;
    logic [WAYS-1:0] miss_waylru;
    logic            flush;
    logic            busy;
    logic            fill_done;
    logic            error;
    logic            mem_cmd_ready;
    logic            mem_cmd_valid;
    logic [ADDR-1:0] mem_cmd_addr;
    logic [LINE-1:0] mem_cmd_len;
    logic            mem_rd_ready;
    logic            mem_rd_valid;
    logic [DATA-1:0] mem_rd_data;
    logic            mem_rd_last;
    logic            wr_init;
    logic [ADDR-1:0] wr_addr;
    logic [WAYS-1:0] wr_way;
    logic            wr_en;
    logic [DATA-1:0] wr_data;
    logic            wr_en_tag;
    logic            wr_last;

    always #5 clk = ~clk;

    dlsc_cpu1_icache_fill #(
        .ADDR(ADDR), .DATA(DATA), .LINE(LINE), .SIZE(SIZE), .WAYS(WAYS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_i          (miss),
        .miss_addr_i     (miss_addr),
        .miss_waylru_i   (miss_waylru),
        .flush_i         (flush),
        .busy_o          (busy),
        .fill_done_o     (fill_done),
        .error_o         (error),
        .mem_cmd_ready_i (mem_cmd_ready),
        .mem_cmd_valid_o (mem_cmd_valid),
        .mem_cmd_addr_o  (mem_cmd_addr),
        .mem_cmd_len_o   (mem_cmd_len),
        .mem_rd_ready_o  (mem_rd_ready),
        .mem_rd_valid_i  (mem_rd_valid),
        .mem_rd_data_i   (mem_rd_data),
        .mem_rd_last_i   (mem_rd_last),
        .wr_init_o       (wr_init),
        .wr_addr_o       (wr_addr),
        .wr_way_o        (wr_way),
        .wr_en_o         (wr_en),
        .wr_data_o       (wr_data),
        .wr_en_tag_o     (wr_en_tag),
        .wr_last_o       (wr_last)
    );

    typedef struct {
        logic [ADDR-1:0] addr;
        logic [WAYS-1:0] way;
        logic [DATA-1:0] data;
        logic            tag;
        logic            last;
    } wr_t;

    typedef struct {
        logic [ADDR-1:0] line;
        logic [WAYS-1:0] way;
    } cmd_t;

    wr_t  exp_wr_q[$];
    cmd_t exp_cmd_q[$];

    int checks = 0;
    int errors = 0;

    // Responder knobs and shared model state
    int cmd_stall  = 0;   // cycles to hold mem_cmd_ready low
    int rd_mode    = 2;   // 0 random gaps, 1 alternate valid/gap, 2 back-to-back
    int bad_last   = -1;  // beat index that also gets mem_rd_last
    bit err_exp    = 1'b0;
    bit resp_busy  = 1'b0;
    int beats_sent = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- memory responder ----------------
    initial begin : responder
        cmd_t            cur;
        bit              seen;
        int              stall;
        logic [ADDR-1:0] held_addr;
        bit              v;
        bit              ph;
        logic [DATA-1:0] d;
        wr_t             e;
        seen = 1'b0; stall = 0; ph = 1'b1; held_addr = '0;
        cur.line = '0; cur.way = '0;
        mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_rd_last = 1'b0;
        forever begin
            @(negedge clk);
            mem_cmd_ready = 1'b0;
            mem_rd_valid  = 1'b0;
            mem_rd_last   = 1'b0;
            if (rst) begin
                resp_busy = 1'b0;
                seen      = 1'b0;
            end else if (!resp_busy) begin
                if (mem_cmd_valid) begin
                    if (!seen) begin
                        seen      = 1'b1;
                        held_addr = mem_cmd_addr;
                        stall     = cmd_stall;
                        chk("cmd_expected", exp_cmd_q.size() != 0, 1);
                        if (exp_cmd_q.size() != 0) begin
                            cur = exp_cmd_q.pop_front();
                            chk("cmd_addr", mem_cmd_addr, cur.line);
                        end else begin
                            cur.line = mem_cmd_addr;
                            cur.way  = '0;
                        end
                        chk("cmd_len", mem_cmd_len, 4'hF);
                    end else begin
                        chk("cmd_stable", mem_cmd_addr, held_addr);
                    end
                    if (stall == 0) begin
                        mem_cmd_ready = 1'b1;
                        resp_busy     = 1'b1;
                        seen          = 1'b0;
                        beats_sent    = 0;
                        ph            = 1'b1;
                    end else begin
                        stall--;
                    end
                end
            end else if (mem_rd_ready) begin
                case (rd_mode)
                    0:       v = ($urandom_range(0, 3) != 0);
                    1:       begin v = ph; ph = ~ph; end
                    default: v = 1'b1;
                endcase
                if (v) begin
                    d            = $urandom;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = d;
                    mem_rd_last  = (beats_sent == BEATS-1) || (beats_sent == bad_last);
                    if (beats_sent == bad_last && bad_last != BEATS-1) err_exp = 1'b1;
                    e.addr = cur.line + ADDR'(beats_sent);
                    e.way  = cur.way;
                    e.data = d;
                    e.tag  = (beats_sent == 0) || (beats_sent == BEATS-1);
                    e.last = (beats_sent == BEATS-1);
                    exp_wr_q.push_back(e);
                    beats_sent++;
                    if (beats_sent == BEATS) resp_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- write-side monitor ----------------
    initial begin : monitor
        wr_t e;
        bit  fd_exp;
        fd_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fd_exp = 1'b0;
            end else begin
                if (fd_exp || fill_done) chk("fill_done", fill_done, fd_exp);
                fd_exp = 1'b0;
                if (wr_en) begin
                    chk("wr_not_in_init", wr_init, 0);
                    chk("wr_expected", exp_wr_q.size() != 0, 1);
                    if (exp_wr_q.size() != 0) begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_way", wr_way, e.way);
                        chk("wr_data", wr_data, e.data);
                        chk("wr_en_tag", wr_en_tag, e.tag);
                        chk("wr_last", wr_last, e.last);
                        fd_exp = e.last;
                    end
                end else if (!wr_init && (wr_en_tag || wr_last)) begin
                    chk("strobe_without_wr", {wr_en_tag, wr_last}, 2'b00);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sweep_from_now();
        int bad = 0;
        int bbad = 0;
        for (int i = 0; i < SWEEP; i++) begin
            if (!(wr_init === 1'b1 && wr_addr === ADDR'(i))) bad++;
            if (busy !== 1'b1 || mem_cmd_valid !== 1'b0) bbad++;
            @(negedge clk);
        end
        chk("init_sweep_seq", bad, 0);
        chk("init_busy", bbad, 0);
        chk("init_end_wr_init", wr_init, 0);
        chk("init_end_busy", busy, 0);
    endtask

    task automatic wait_init_sweep(input bit require_busy);
        int n = 0;
        int bbad = 0;
        while (wr_init !== 1'b1 && n < 3000) begin
            if (require_busy && busy !== 1'b1) bbad++;
            @(negedge clk);
            n++;
        end
        chk("init_start", wr_init, 1);
        if (require_busy) chk("busy_until_init", bbad, 0);
        sweep_from_now();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(busy === 1'b0 && !resp_busy && exp_wr_q.size() == 0 && exp_cmd_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 3000, 1);
    endtask

    task automatic issue_miss(input logic [ADDR-1:0] a, input logic [WAYS-1:0] w);
        cmd_t c;
        int   n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_miss", busy, 0);
        miss = 1'b1; miss_addr = a; miss_waylru = w;
        c.line = a & ~ADDR'(BEATS-1);
        c.way  = w;
        exp_cmd_q.push_back(c);
        @(negedge clk);
        chk("busy_after_miss", busy, 1);
        // A miss presented while busy must be ignored.
        miss_addr = $urandom; miss_waylru = ~w;
        @(negedge clk);
        miss = 1'b0;
    endtask

    task automatic do_fill(input logic [ADDR-1:0] a, input logic [WAYS-1:0] w);
        issue_miss(a, w);
        wait_idle("fill_complete");
        chk("error_flag", error, err_exp);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (!(resp_busy && beats_sent >= k) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("burst_progress", n < 3000, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        miss = 1'b0; miss_addr = '0; miss_waylru = '0; flush = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy, 1);
        chk("rst_wr_init", wr_init, 1);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_rd_ready", mem_rd_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_en_tag", wr_en_tag, 0);
        chk("rst_wr_last", wr_last, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_way", wr_way, 0);

        rst = 1'b0;
        sweep_from_now();

        // Directed line 0x120, back-to-back data
        cmd_stall = 0; rd_mode = 2;
        do_fill(30'h123, 2'b01);

        // Command stalled 5 cycles, data alternating valid/gap, way 1
        cmd_stall = 5; rd_mode = 1;
        do_fill(30'h0ABCDE7, 2'b10);

        // Random fills
        for (int n = 0; n < 20; n++) begin
            cmd_stall = $urandom_range(0, 3);
            rd_mode   = $urandom_range(0, 2);
            do_fill($urandom, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
        end

        // Flush after beat 7: burst drains, then a full sweep, busy held
        cmd_stall = 1; rd_mode = 0;
        issue_miss($urandom, 2'b10);
        wait_beats(8);
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        wait_init_sweep(1'b1);
        chk("flush_burst_drained", exp_wr_q.size(), 0);
        chk("flush_no_cmd", exp_cmd_q.size(), 0);

        // Flush together with a miss while idle: miss dropped, sweep starts
        miss = 1'b1; miss_addr = 30'h3F0; miss_waylru = 2'b01; flush = 1'b1;
        @(negedge clk);
        miss = 1'b0; flush = 1'b0;
        sweep_from_now();

        // Flush in the middle of a sweep restarts it at 0
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_sweep_init", wr_init, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sweep_from_now();

        // Fill after the sweeps still works
        cmd_stall = 0; rd_mode = 0;
        do_fill($urandom, 2'b01);

        // Early mem_rd_last on beat 14: error sets and sticks, fill ends on count
        bad_last = 14;
        do_fill($urandom, 2'b10);
        chk("error_set", error, 1);
        bad_last = -1;
        do_fill($urandom, 2'b01);
        chk("error_sticky", error, 1);

        // Asynchronous reset in the middle of a burst
        rd_mode = 2; cmd_stall = 0;
        issue_miss($urandom, 2'b10);
        wait_beats(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1);
        chk("arst_wr_init", wr_init, 1);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_rd_ready", mem_rd_ready, 0);
        chk("arst_error", error, 0);
        @(negedge clk);
        @(negedge clk);
        exp_wr_q.delete();
        exp_cmd_q.delete();
        err_exp = 1'b0;
        rst = 1'b0;
        sweep_from_now();
        chk("error_after_rst", error, 0);

        do_fill(30'h123, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL global_timeout: simulation still running after 90000 cycles");
        $fatal(1, "timeout");
    end

endmodule
